// File: rtl/memory_responder_pkg.sv
// Shared definitions for memory_responder: loader state encodings and default sizing.
package memory_responder_pkg;

  localparam int         DEF_ADDR_W      = 8;
  localparam logic [7:0] DEF_PROTECT_TOP = 8'h10;

  typedef enum logic {
    MEM_STATE_LOAD = 1'b0,
    MEM_STATE_RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/memory_responder_mem_loader.sv
// Program loader FSM: owns the LOAD/RUN state, the fill pointer and the load_done pulse.
module mem_loader
  import memory_responder_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit AUTOLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic              load_last,
  output logic [ADDR_W-1:0] ptr,
  output logic              load_we,
  output logic              load_done,
  output logic              in_load
);

  localparam mem_state_e RESET_STATE = AUTOLOAD ? MEM_STATE_LOAD : MEM_STATE_RUN;
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  mem_state_e state_r;

  assign in_load = (state_r == MEM_STATE_LOAD);
  assign load_we = in_load & load_valid;

  // State, pointer and completion pulse; pointer wraps to 0 whenever LOAD is left or entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= RESET_STATE;
      ptr       <= {ADDR_W{1'b0}};
      load_done <= 1'b0;
    end else begin
      case (state_r)
        MEM_STATE_LOAD: begin
          if (load_valid && (load_last || ptr == PTR_MAX)) begin
            state_r   <= MEM_STATE_RUN;
            ptr       <= {ADDR_W{1'b0}};
            load_done <= 1'b1;
          end else if (load_valid) begin
            ptr       <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            load_done <= 1'b0;
          end else begin
            load_done <= 1'b0;
          end
        end
        MEM_STATE_RUN: begin
          load_done <= 1'b0;
          if (load_req) begin
            state_r <= MEM_STATE_LOAD;
            ptr     <= {ADDR_W{1'b0}};
          end else begin
            state_r <= MEM_STATE_RUN;
          end
        end
        default: begin
          state_r   <= MEM_STATE_RUN;
          ptr       <= {ADDR_W{1'b0}};
          load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: RAM on the shared CPU bus plus program loader.
// Optional MEM_WRITE_PROTECT_EN drops CPU writes below PROTECT_TOP and counts them.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int               ADDR_W      = DEF_ADDR_W,
  parameter bit               AUTOLOAD    = 1'b1,
  parameter logic [ADDR_W-1:0] PROTECT_TOP = DEF_PROTECT_TOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_clk,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              c_ri,
  input  logic              c_ro,
  inout  wire  [7:0]        bus,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_hold,
`ifdef MEM_WRITE_PROTECT_EN
  output logic [7:0]        prot_viol_cnt,
`endif
  output logic              coll_err
);

`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic [7:0]        mem_r [2**ADDR_W];
  logic              mem_clk_q_r;
  logic              strobe_s;
  logic              in_load_s;
  logic              load_we_s;
  logic [ADDR_W-1:0] ptr_s;
  logic              run_s;
  logic              read_en_s;
  logic              wr_req_s;
  logic              prot_hit_s;
  logic              cpu_we_s;

  mem_loader #(.ADDR_W(ADDR_W), .AUTOLOAD(AUTOLOAD)) u_loader (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .load_valid (load_valid),
    .load_last  (load_last),
    .ptr        (ptr_s),
    .load_we    (load_we_s),
    .load_done  (load_done),
    .in_load    (in_load_s)
  );

  assign load_ready = in_load_s;
  assign cpu_hold   = in_load_s;
  assign run_s      = ~in_load_s;
  assign strobe_s   = mem_clk & ~mem_clk_q_r;
  assign read_en_s  = run_s & c_ro & ~c_ri;
  assign wr_req_s   = run_s & strobe_s & c_ri & ~c_ro;
  assign prot_hit_s = PROT_EN & (addr_bus < PROTECT_TOP);
  assign cpu_we_s   = wr_req_s & ~prot_hit_s;

  // Zero-latency read so data settles before the CPU samples it.
  assign bus = read_en_s ? mem_r[addr_bus] : 8'bzzzz_zzzz;

  // RAM array: loader has priority, though CPU writes cannot occur during LOAD anyway.
  always_ff @(posedge clk) begin
    if (load_we_s) begin
      mem_r[ptr_s] <= load_data;
    end else if (cpu_we_s) begin
      mem_r[addr_bus] <= bus;
    end
  end

  // Strobe edge history and sticky collision flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_clk_q_r <= 1'b0;
      coll_err    <= 1'b0;
    end else begin
      mem_clk_q_r <= mem_clk;
      if (run_s && strobe_s && c_ri && c_ro) begin
        coll_err <= 1'b1;
      end
    end
  end

`ifdef MEM_WRITE_PROTECT_EN
  // Saturating count of dropped protected writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prot_viol_cnt <= 8'h00;
    end else if (wr_req_s && prot_hit_s && prot_viol_cnt != 8'hFF) begin
      prot_viol_cnt <= prot_viol_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder; bus has pull-ups so an undriven bus reads 8'hFF.
module tb_memory_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_clk = 1'b0;
  logic [7:0] addr_bus = 8'h00;
  logic       c_ri = 1'b0;
  logic       c_ro = 1'b0;
  tri   [7:0] bus;
  logic [7:0] bus_drv = 8'h00;
  logic       bus_en = 1'b0;
  logic       load_req = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       load_done;
  logic       cpu_hold;
  logic       coll_err;
`ifdef MEM_WRITE_PROTECT_EN
  logic [7:0] prot_viol_cnt;
`endif

  int errors = 0;
  int checks = 0;

  assign bus = bus_en ? bus_drv : 8'bzzzz_zzzz;
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (bus[g]);
  end

  always #5 clk = ~clk;

  memory_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_clk    (mem_clk),
    .addr_bus   (addr_bus),
    .c_ri       (c_ri),
    .c_ro       (c_ro),
    .bus        (bus),
    .load_req   (load_req),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .cpu_hold   (cpu_hold),
`ifdef MEM_WRITE_PROTECT_EN
    .prot_viol_cnt (prot_viol_cnt),
`endif
    .coll_err   (coll_err)
  );

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    addr_bus = a;
    c_ro = 1'b1;
    #1;
    v = bus;
    c_ro = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_bus = a; bus_drv = d; bus_en = 1'b1; c_ri = 1'b1;
    @(negedge clk);
    mem_clk = 1'b1;
    @(negedge clk);
    mem_clk = 1'b0;
    @(negedge clk);
    c_ri = 1'b0; bus_en = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    @(negedge clk);
    load_valid = 1'b1; load_data = d; load_last = last;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
    checks++; if (coll_err !== 1'b0) begin errors++; $display("FAIL reset_coll_err got=%b exp=0", coll_err); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load();
    logic [7:0] v;
    logic [7:0] bytes [3];
    bytes[0] = 8'h1E; bytes[1] = 8'h2F; bytes[2] = 8'hE0;
    for (int i = 0; i < 3; i++) begin
      load_byte(bytes[i], (i == 2) ? 1'b1 : 1'b0);
      addr_bus = 8'h00; c_ro = 1'b1;
      #1;
      checks++; if (bus !== 8'hFF) begin errors++; $display("FAIL load_bus_hiz byte=%0d got=%h exp=FF", i, bus); end
      c_ro = 1'b0;
    end
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_pulse got=%b exp=1", load_done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL load_cpu_hold_fall got=%b exp=0", cpu_hold); end
    @(negedge clk);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_width got=%b exp=0", load_done); end
    for (int i = 0; i < 3; i++) begin
      rd(i[7:0], v);
      checks++; if (v !== bytes[i]) begin errors++; $display("FAIL load_mem addr=%0d got=%h exp=%h", i, v, bytes[i]); end
    end
  endtask

  task automatic test_read();
    @(negedge clk);
    addr_bus = 8'h01; c_ro = 1'b1;
    #1;
    checks++; if (bus !== 8'h2F) begin errors++; $display("FAIL read_01 got=%h exp=2F", bus); end
    c_ro = 1'b0;
    #1;
    checks++; if (bus !== 8'hFF) begin errors++; $display("FAIL read_release got=%h exp=FF", bus); end
  endtask

  task automatic test_write();
    logic [7:0] v;
    wr(8'h40, 8'hA5);
    rd(8'h40, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL write_40 got=%h exp=A5", v); end
    wr(8'h41, 8'h3C);
    rd(8'h41, v);
    checks++; if (v !== 8'h3C) begin errors++; $display("FAIL write_41 got=%h exp=3C", v); end
    rd(8'h40, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL write_40_kept got=%h exp=A5", v); end
  endtask

  task automatic test_collision();
    logic [7:0] v;
    @(negedge clk);
    addr_bus = 8'h01; c_ri = 1'b1; c_ro = 1'b1; bus_en = 1'b0;
    @(negedge clk);
    mem_clk = 1'b1;
    #1;
    checks++; if (bus !== 8'hFF) begin errors++; $display("FAIL coll_bus_hiz got=%h exp=FF", bus); end
    @(negedge clk);
    mem_clk = 1'b0;
    checks++; if (coll_err !== 1'b1) begin errors++; $display("FAIL coll_err_set got=%b exp=1", coll_err); end
    @(negedge clk);
    c_ri = 1'b0; c_ro = 1'b0;
    rd(8'h01, v);
    checks++; if (v !== 8'h2F) begin errors++; $display("FAIL coll_ram_unchanged got=%h exp=2F", v); end
  endtask

  task automatic test_full_load();
    logic [7:0] v;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL full_enter_load got=%b exp=1", cpu_hold); end
    for (int i = 0; i < 256; i++) load_byte(i[7:0] ^ 8'h5A, 1'b0);
    @(negedge clk);
    load_valid = 1'b0;
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL full_load_done got=%b exp=1", load_done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL full_run got=%b exp=0", cpu_hold); end
    rd(8'h00, v);
    checks++; if (v !== 8'h5A) begin errors++; $display("FAIL full_mem_00 got=%h exp=5A", v); end
    rd(8'hFF, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL full_mem_FF got=%h exp=A5", v); end
    checks++; if (coll_err !== 1'b1) begin errors++; $display("FAIL coll_err_sticky got=%b exp=1", coll_err); end
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reload_hold got=%b exp=1", cpu_hold); end
    load_byte(8'hC3, 1'b1);
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    rd(8'h00, v);
    checks++; if (v !== 8'hC3) begin errors++; $display("FAIL reload_addr0 got=%h exp=C3", v); end
    rd(8'h01, v);
    checks++; if (v !== 8'h5B) begin errors++; $display("FAIL reload_addr1 got=%h exp=5B", v); end
  endtask

`ifdef MEM_WRITE_PROTECT_EN
  task automatic test_protect();
    logic [7:0] v;
    wr(8'h05, 8'h77);
    rd(8'h05, v);
    checks++; if (v !== 8'h5F) begin errors++; $display("FAIL prot_drop got=%h exp=5F", v); end
    checks++; if (prot_viol_cnt !== 8'd1) begin errors++; $display("FAIL prot_cnt1 got=%0d exp=1", prot_viol_cnt); end
    wr(8'h10, 8'h88);
    rd(8'h10, v);
    checks++; if (v !== 8'h88) begin errors++; $display("FAIL prot_top_write got=%h exp=88", v); end
    checks++; if (prot_viol_cnt !== 8'd1) begin errors++; $display("FAIL prot_cnt_hold got=%0d exp=1", prot_viol_cnt); end
  endtask
`endif

  task automatic test_reset_midload();
    logic [7:0] v;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    @(negedge clk);
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (coll_err !== 1'b0) begin errors++; $display("FAIL midload_coll_clear got=%b exp=0", coll_err); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL midload_hold got=%b exp=1", cpu_hold); end
    @(negedge clk);
    reset = 1'b1;
    load_byte(8'h33, 1'b1);
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    rd(8'h00, v);
    checks++; if (v !== 8'h33) begin errors++; $display("FAIL midload_addr0 got=%h exp=33", v); end
    rd(8'h01, v);
    checks++; if (v !== 8'h22) begin errors++; $display("FAIL midload_addr1 got=%h exp=22", v); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_read();
    test_write();
    test_collision();
    test_full_load();
`ifdef MEM_WRITE_PROTECT_EN
    test_protect();
`endif
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side end of the CPU memory interface: 2^ADDR_W x 8 RAM answering CPU read (c_ro) and write (c_ri) requests on the shared tristate bus at addr_bus.
- Includes a byte-stream program loader FSM that fills RAM from address 0 while holding the CPU, then hands control to the CPU.
- Sits beside cpu at top level, sharing bus, addr_bus, c_ri, c_ro and mem_clk.

Parameters:
- ADDR_W, 8, address width; RAM depth is 2^ADDR_W bytes.
- AUTOLOAD, 1, reset enters LOAD when 1, RUN when 0.
- PROTECT_TOP, 8'h10, first writable address; used only with MEM_WRITE_PROTECT_EN.

Ports:
- clk  input  1  system clock (same clk that drives cpu).
- reset  input  1  asynchronous, active-low reset.
- mem_clk  input  1  memory phase strobe from CPU; high for exactly one clk period per CPU cycle.
- addr_bus  input  ADDR_W  CPU memory address.
- c_ri  input  1  CPU write request (RAM in).
- c_ro  input  1  CPU read request (RAM out).
- bus  inout  8  shared data bus.
- load_req  input  1  pulse; re-enter LOAD from RUN.
- load_valid  input  1  loader byte valid.
- load_data  input  8  loader byte.
- load_last  input  1  marks final loader byte; qualified by load_valid.
- load_ready  output  1  loader may transfer this cycle.
- load_done  output  1  one-clk pulse when LOAD completes.
- cpu_hold  output  1  high while in LOAD; top level gates CPU clock or holds it in reset.
- coll_err  output  1  sticky: c_ri and c_ro seen high together at a strobe.

Behaviour:
- Reset (reset=0, async): state=LOAD if AUTOLOAD else RUN; ptr=0; mem_clk_q=0; load_done=0; coll_err=0. RAM contents are not cleared.
- Strobe: mem_clk_q registers mem_clk each clk. strobe = mem_clk & ~mem_clk_q (one clk per CPU cycle).
- load_ready = (state==LOAD). cpu_hold = (state==LOAD).
- RUN, read: bus = mem[addr_bus] combinationally whenever c_ro=1 and c_ri=0; otherwise bus is high-Z. Zero-cycle latency, so data is stable before the CPU internal_clk edge.
- RUN, write: on a clk edge with strobe=1, c_ri=1 and c_ro=0, mem[addr_bus] <= bus. A write sustained across several clk is still written exactly once.
- Collision (strobe with c_ri=1 and c_ro=1): no write, bus stays high-Z, coll_err set to 1 until reset.
- LOAD: bus is never driven and CPU strobes are ignored. Each clk with load_valid=1 writes mem[ptr] <= load_data and increments ptr.
- LOAD exit: when the accepted byte has load_last=1, or ptr==2^ADDR_W-1, the FSM enters RUN next clk, pulses load_done for one clk and resets ptr to 0.
- load_req: in RUN, enters LOAD next clk with ptr=0. Ignored while in LOAD.
- Reset mid-load: the loader restarts from address 0; bytes already written stay in RAM.
- Address wrap: ptr and addr_bus are ADDR_W bits; there is no out-of-range access.

Optional Feature:
- Macro MEM_WRITE_PROTECT_EN.
- Defined: RUN-mode CPU writes to addresses < PROTECT_TOP are dropped and increment an 8-bit saturating output prot_viol_cnt (reset 0). The loader is never protected.
- Undefined: all addresses are writable and the prot_viol_cnt port does not exist.

Decomposition:
- Shared package/include (alongside the existing parameters file): `MEM_STATE_LOAD / `MEM_STATE_RUN encodings, default ADDR_W and PROTECT_TOP.
- One natural sub-module: mem_loader (LOAD/RUN FSM, ptr, handshake, load_done). The top holds the RAM array, strobe detect, tristate drive and collision/protect logic.

Test Plan:
- AUTOLOAD=1: release reset, stream 8'h1E,8'h2F,8'hE0 with load_last on the third byte -> load_done pulses 1 clk after the third accept; cpu_hold falls; mem[0..2]=1E,2F,E0; bus high-Z during load.
- RUN read: addr_bus=8'h01, c_ro=1 -> bus=8'h2F with no delay. c_ro=0 -> bus=Z.
- RUN write: addr_bus=8'h40, bus=8'hA5, c_ri=1 held for 3 clk spanning one mem_clk pulse -> a single write, then a read of 8'h40 returns A5.
- Collision: c_ri=c_ro=1 at strobe -> RAM unchanged, bus=Z, coll_err=1 until reset.
- Full load: 256 bytes with no load_last -> RUN entered after byte 255, ptr=0. A subsequent load_req pulse -> cpu_hold=1 and the next byte lands at address 0.
- MEM_WRITE_PROTECT_EN, PROTECT_TOP=8'h10: CPU write to 8'h05 -> dropped, prot_viol_cnt=1. Write to 8'h10 -> succeeds.
